// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART receiver: parity modes, FSM encoding
// and the 3-sample majority vote.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchronizer for the serial line plus the mid-bit 3-sample majority
// voter; the vote is valid on the baud tick where the counter is at OVERSAMPLE/2+1.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             rx_i,
  input  logic             baud_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             rx_sync_o,
  output logic             vote_o
);

  localparam logic [CNT_W-1:0] C_S0 = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] C_S1 = CNT_W'(OVERSAMPLE / 2);

  logic [1:0] r_sync;
  logic [1:0] r_samp;

  // NOTE: the synchronizer resets to the idle line level so leaving reset can
  // never look like a start bit.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_sync <= 2'b11;
      r_samp <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      r_sync <= {r_sync[0], rx_i};
      if (baud_i && (cnt_i == C_S0)) r_samp[0] <= r_sync[1];
      if (baud_i && (cnt_i == C_S1)) r_samp[1] <= r_sync[1];
    end
  end

  assign rx_sync_o = r_sync[1];
  assign vote_o    = majority3(r_samp[0], r_samp[1], r_sync[1]);

endmodule

// File: rtl/uart_rx_framed.sv
// Oversampling UART receiver with optional parity, 1 or 2 checked stop bits,
// break detection and a one-deep valid/ready output holding register.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int WORD_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 rx_i,
  input  logic                 baud_i,
  output logic [WORD_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 break_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] C_VOTE      = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [CNT_W-1:0] C_LAST      = CNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       C_DATA_N    = 4'(WORD_BITS);
  localparam logic [3:0]       C_STOP_LAST = 4'(STOP_BITS - 1);

  rx_state_e              r_state, w_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [3:0]             r_bit_cnt;
  logic [WORD_BITS-1:0]   r_shift;
  logic                   r_par_bit, r_stop_hi, r_stop_lo;
  logic [WORD_BITS-1:0]   r_data;
  logic                   r_valid, r_par_err, r_frame_err, r_break, r_overrun;
  logic                   w_rx_sync, w_vote, w_vote_tick, w_bit_end, w_complete;
  logic                   w_stop_low, w_par_exp, w_par_err, w_break;

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE), .CNT_W(CNT_W)) u_sampler (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .rx_i      (rx_i),
    .baud_i    (baud_i),
    .cnt_i     (r_cnt),
    .rx_sync_o (w_rx_sync),
    .vote_o    (w_vote)
  );

  assign w_vote_tick = baud_i && (r_cnt == C_VOTE);
  assign w_bit_end   = baud_i && (r_cnt == C_LAST);
  assign w_complete  = (r_state == ST_STOP) && w_vote_tick && (r_bit_cnt == C_STOP_LAST);
  assign w_stop_low  = r_stop_lo | ~w_vote;
  assign w_par_exp   = (^r_shift) ^ (PARITY == PARITY_ODD);
  assign w_par_err   = (PARITY != PARITY_NONE) && (r_par_bit != w_par_exp);
  assign w_break     = (r_shift == '0) && ((PARITY == PARITY_NONE) || !r_par_bit) &&
                       !r_stop_hi && !w_vote;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves w_next unassigned (no latch).
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:      if (!w_rx_sync) w_next = ST_START;
      ST_START: begin
        if (w_vote_tick && w_vote) w_next = ST_IDLE;
        else if (w_bit_end)        w_next = ST_DATA;
      end
      ST_DATA:      if (w_bit_end && (r_bit_cnt == C_DATA_N))
                      w_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (w_bit_end) w_next = ST_STOP;
      ST_STOP:      if (w_complete) w_next = w_stop_low ? ST_WAIT_HIGH : ST_IDLE;
      ST_WAIT_HIGH: if (w_rx_sync) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_stop_hi <= 1'b0;
      r_stop_lo <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) || (r_state == ST_WAIT_HIGH)) r_cnt <= '0;
      else if (baud_i) r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;

      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= '0;
          r_par_bit <= 1'b0;
          r_stop_hi <= 1'b0;
          r_stop_lo <= 1'b0;
        end
        ST_DATA: begin
          if (w_vote_tick) begin
            r_shift   <= {w_vote, r_shift[WORD_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          if (w_bit_end && (r_bit_cnt == C_DATA_N)) r_bit_cnt <= '0;
        end
        ST_PARITY: if (w_vote_tick) r_par_bit <= w_vote;
        ST_STOP: begin
          if (w_vote_tick) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_vote) r_stop_hi <= 1'b1;
            else        r_stop_lo <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A completed frame loads unless the held one is still unaccepted; then it is dropped.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_break     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_complete) begin
        if (!r_valid || ready_i) begin
          r_data      <= r_shift;
          r_valid     <= 1'b1;
          r_par_err   <= w_par_err;
          r_frame_err <= w_stop_low;
          r_break     <= w_break;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o       = r_data;
  assign valid_o      = r_valid;
  assign parity_err_o = r_par_err;
  assign frame_err_o  = r_frame_err;
  assign break_o      = r_break;
  assign overrun_o    = r_overrun;
  assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: three instances (8N1, 8E1, 8N2) share clock,
// reset and a baud tick every second clock; one bit period is 32 clocks.
module tb_uart_rx_framed;

  localparam int BIT_CLKS = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic baud = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) baud <= ~baud;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic       ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;
  logic [7:0] data_a, data_b, data_c;
  logic       valid_a, valid_b, valid_c;
  logic       perr_a, perr_b, perr_c;
  logic       ferr_a, ferr_b, ferr_c;
  logic       brk_a, brk_b, brk_c;
  logic       ovr_a, ovr_b, ovr_c;
  logic       busy_a, busy_b, busy_c;

  uart_rx_framed #(.WORD_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u_n1 (
    .clk_i(clk), .reset_ni(reset_n), .rx_i(rx_a), .baud_i(baud), .data_o(data_a),
    .valid_o(valid_a), .ready_i(ready_a), .parity_err_o(perr_a), .frame_err_o(ferr_a),
    .break_o(brk_a), .overrun_o(ovr_a), .busy_o(busy_a));

  uart_rx_framed #(.WORD_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) u_e1 (
    .clk_i(clk), .reset_ni(reset_n), .rx_i(rx_b), .baud_i(baud), .data_o(data_b),
    .valid_o(valid_b), .ready_i(ready_b), .parity_err_o(perr_b), .frame_err_o(ferr_b),
    .break_o(brk_b), .overrun_o(ovr_b), .busy_o(busy_b));

  uart_rx_framed #(.WORD_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(2)) u_n2 (
    .clk_i(clk), .reset_ni(reset_n), .rx_i(rx_c), .baud_i(baud), .data_o(data_c),
    .valid_o(valid_c), .ready_i(ready_c), .parity_err_o(perr_c), .frame_err_o(ferr_c),
    .break_o(brk_c), .overrun_o(ovr_c), .busy_o(busy_c));

  // Pulse counters sampled on the falling edge, away from the active edge.
  int   nv_a = 0, no_a = 0, nv_b = 0, no_b = 0, nv_c = 0, no_c = 0, rise_a = 0;
  logic va_q = 1'b0;

  always @(negedge clk) begin
    nv_a <= nv_a + int'(valid_a);
    no_a <= no_a + int'(ovr_a);
    nv_b <= nv_b + int'(valid_b);
    no_b <= no_b + int'(ovr_b);
    nv_c <= nv_c + int'(valid_c);
    no_c <= no_c + int'(ovr_c);
    if (valid_a && !va_q) rise_a <= cyc;
    va_q <= valid_a;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int sel, input logic v);
    case (sel)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(sel, bits[i]);
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic align();
    while (!baud) @(negedge clk);
  endtask

  function automatic logic [15:0] fr_n1(input logic [7:0] d);
    return {6'h0, 1'b1, d, 1'b0};
  endfunction

  function automatic logic [15:0] fr_11(input logic [7:0] d, input logic b9, input logic b10);
    return {5'h0, b10, b9, d, 1'b0};
  endfunction

  int v0, o0, t0, k;

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    check("rst_valid", {31'b0, valid_a}, 32'd0);
    check("rst_busy", {31'b0, busy_a}, 32'd0);
    check("rst_data", {24'b0, data_a}, 32'd0);
    check("rst_flags", {28'b0, perr_a, ferr_a, brk_a, ovr_a}, 32'd0);
    check("rst_busy_c", {31'b0, busy_c}, 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5, consumer always ready
    v0 = nv_a; o0 = no_a;
    align();
    send_bits(0, fr_n1(8'hA5), 10);
    repeat (BIT_CLKS) @(negedge clk);
    check("a5_data", {24'b0, data_a}, 32'hA5);
    check("a5_valid_cycles", nv_a - v0, 32'd1);
    check("a5_flags", {29'b0, perr_a, ferr_a, brk_a}, 32'd0);
    check("a5_overrun", no_a - o0, 32'd0);
    check("a5_busy", {31'b0, busy_a}, 32'd0);

    // Start-bit glitch of 4 baud ticks
    v0 = nv_a;
    align();
    set_rx(0, 1'b0);
    repeat (8) @(negedge clk);
    set_rx(0, 1'b1);
    check("glitch_busy_hi", {31'b0, busy_a}, 32'd1);
    repeat (24) @(negedge clk);
    check("glitch_busy_lo", {31'b0, busy_a}, 32'd0);
    check("glitch_no_valid", nv_a - v0, 32'd0);

    // 8E1: 0x07 with wrong parity 0, then 0x03 with correct parity 0
    v0 = nv_b;
    align();
    send_bits(1, fr_11(8'h07, 1'b0, 1'b1), 11);
    repeat (BIT_CLKS) @(negedge clk);
    check("e1_07_data", {24'b0, data_b}, 32'h07);
    check("e1_07_perr", {31'b0, perr_b}, 32'd1);
    check("e1_07_ferr", {31'b0, ferr_b}, 32'd0);
    check("e1_07_valid", nv_b - v0, 32'd1);
    align();
    send_bits(1, fr_11(8'h03, 1'b0, 1'b1), 11);
    repeat (BIT_CLKS) @(negedge clk);
    check("e1_03_data", {24'b0, data_b}, 32'h03);
    check("e1_03_perr", {31'b0, perr_b}, 32'd0);

    // 8N2: good frame, then second stop bit low with the line staying low
    v0 = nv_c;
    align();
    send_bits(2, fr_11(8'h5A, 1'b1, 1'b1), 11);
    repeat (BIT_CLKS) @(negedge clk);
    check("n2_5a_data", {24'b0, data_c}, 32'h5A);
    check("n2_5a_ferr", {31'b0, ferr_c}, 32'd0);
    v0 = nv_c;
    align();
    send_bits(2, fr_11(8'h3C, 1'b1, 1'b0), 11);
    repeat (3 * BIT_CLKS) @(negedge clk);
    check("n2_3c_data", {24'b0, data_c}, 32'h3C);
    check("n2_3c_ferr", {31'b0, ferr_c}, 32'd1);
    check("n2_3c_brk", {31'b0, brk_c}, 32'd0);
    check("n2_wait_high_busy", {31'b0, busy_c}, 32'd1);
    set_rx(2, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    check("n2_idle_after_rise", {31'b0, busy_c}, 32'd0);
    check("n2_one_frame", nv_c - v0, 32'd1);

    // Break: line low for 20 bit times
    v0 = nv_a;
    align();
    set_rx(0, 1'b0);
    repeat (20 * BIT_CLKS) @(negedge clk);
    check("brk_data", {24'b0, data_a}, 32'h00);
    check("brk_flag", {31'b0, brk_a}, 32'd1);
    check("brk_ferr", {31'b0, ferr_a}, 32'd1);
    check("brk_busy", {31'b0, busy_a}, 32'd1);
    set_rx(0, 1'b1);
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("brk_busy_lo", {31'b0, busy_a}, 32'd0);
    check("brk_one_frame", nv_a - v0, 32'd1);

    // Overrun: 0x11 then 0x22 back-to-back with consumer stalled
    ready_a = 1'b0;
    o0 = no_a;
    align();
    t0 = cyc;
    send_bits(0, fr_n1(8'h11), 10);
    send_bits(0, fr_n1(8'h22), 10);
    repeat (4) @(negedge clk);
    check("ovr_valid", {31'b0, valid_a}, 32'd1);
    check("ovr_data_kept", {24'b0, data_a}, 32'h11);
    check("ovr_pulses", no_a - o0, 32'd1);
    k = rise_a - t0;

    // Frame completing in the same clk as ready_i=1 loads without overrun
    align();
    t0 = cyc;
    o0 = no_a;
    fork
      send_bits(0, fr_n1(8'h33), 10);
      begin
        repeat (k - 1) @(negedge clk);
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("same_clk_data", {24'b0, data_a}, 32'h33);
    check("same_clk_valid", {31'b0, valid_a}, 32'd1);
    check("same_clk_no_ovr", no_a - o0, 32'd0);
    ready_a = 1'b1;
    repeat (4) @(negedge clk);
    check("drain_valid", {31'b0, valid_a}, 32'd0);

    // Asynchronous reset in the middle of a frame
    v0 = nv_a; o0 = no_a;
    align();
    send_bits(0, fr_n1(8'h5A), 4);
    #3 reset_n = 1'b0;
    #1 check("midrst_busy", {31'b0, busy_a}, 32'd0);
    set_rx(0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8 * BIT_CLKS) @(negedge clk);
    check("midrst_no_valid", nv_a - v0, 32'd0);
    check("midrst_no_ovr", no_a - o0, 32'd0);
    check("midrst_idle", {31'b0, busy_a}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_framed.md
UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 Parameter WORD_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, baud_i ticks per bit; even, 8..32.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, stop bits checked: 1 or 2.
REQ-005 Port clk_i, input, 1, the single clock.
REQ-006 Port reset_ni, input, 1, asynchronous active-low reset.
REQ-007 Port rx_i, input, 1, asynchronous serial line; idle high.
REQ-008 Port baud_i, input, 1, one-clk oversample tick from the baud generator.
REQ-009 Port data_o, output, WORD_BITS, received word.
REQ-010 Port valid_o, output, 1, data_o and the error flags hold a frame.
REQ-011 Port ready_i, input, 1, consumer accepts the frame when valid_o is high.
REQ-012 Port parity_err_o, output, 1, parity mismatch for the held frame.
REQ-013 Port frame_err_o, output, 1, a stop bit sampled low for the held frame.
REQ-014 Port break_o, output, 1, the held frame is all-zero including stop bits.
REQ-015 Port overrun_o, output, 1, one-clk pulse when a completed frame is dropped.
REQ-016 Port busy_o, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-017 rx_i SHALL pass through a 2-flop synchronizer that resets to 1; all logic uses the synchronized value.
REQ-018 Bit value SHALL be the majority of 3 samples taken on baud ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of each bit period.
REQ-019 FSM states SHALL be IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-020 IDLE->START on a synchronized low, clearing the tick counter.
REQ-021 START SHALL vote the start bit; a vote of 1 returns to IDLE (glitch rejection) with no output; a vote of 0 proceeds to DATA at the end of the bit period.
REQ-022 DATA SHALL shift in WORD_BITS votes LSB first, then go to PARITY if PARITY!=0, else STOP.
REQ-023 PARITY SHALL compare the vote with the XOR of the data bits (even) or its inverse (odd).
REQ-024 STOP SHALL vote STOP_BITS bits and complete the frame on the last stop-bit vote, without waiting for the end of the bit period.
REQ-025 On completion, a frame with any stop vote of 0 SHALL enter WAIT_HIGH, otherwise IDLE; WAIT_HIGH->IDLE on synchronized high.
REQ-026 break_o SHALL be set when the data, parity and all stop votes are 0; frame_err_o SHALL also be set.
REQ-027 On completion, if valid_o is low, or valid_o and ready_i are both high, then data_o and the flags SHALL load and valid_o SHALL be high on the next clk.
REQ-028 On completion with valid_o high and ready_i low, the new frame SHALL be dropped, the held frame kept, and overrun_o pulsed for one clk.
REQ-029 valid_o SHALL clear on the clk after valid_o and ready_i are both high, unless REQ-027 reloads it in the same cycle.
REQ-030 The tick counter SHALL be $clog2(OVERSAMPLE) bits wide, advance only on baud_i, and wrap to 0 at OVERSAMPLE-1.

Reset
REQ-031 reset_ni low SHALL force IDLE, counters 0, the shift register 0, the synchronizer 1, and all outputs 0, immediately and asynchronously.
REQ-032 Reset mid-frame SHALL discard the partial frame with no valid_o or overrun_o.

Structure
REQ-033 Package uart_pkg SHALL hold the parity-mode constants (NONE/ODD/EVEN) and the FSM state encoding.
REQ-034 The synchronizer plus 3-sample majority voter SHALL be sub-module uart_rx_sampler.

Verification
REQ-035 8N1, OVERSAMPLE=16, frame 0xA5, ready_i=1 -> data_o=0xA5 and valid_o high for 1 clk, all flags 0.
REQ-036 8E1, frame 0x07 sent with parity bit 0 -> data_o=0x07 and parity_err_o=1.
REQ-037 Low pulse of 4 baud ticks on the idle line -> no valid_o; busy_o returns low within 16 ticks.
REQ-038 8N2, second stop bit low -> frame_err_o=1; the FSM holds WAIT_HIGH until rx_i rises.
REQ-039 rx_i held low for 20 bit times -> one frame with data_o=0x00, break_o=1, frame_err_o=1, then no further frames until rx_i rises.
REQ-040 Two frames 0x11, 0x22 back-to-back with ready_i=0 -> data_o stays 0x11 and overrun_o pulses once; a frame completing in the same clk as ready_i=1 loads with no overrun.
